// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg                                                            |
// | Timing constants and state encoding for the VGA sync monitor.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam logic [9:0] COORD_MAX = 10'd1023;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_t;
endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge_det                                                      |
// | Registers a sync input and flags its 1->0 transition.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_fall
);
  logic r_q;
  logic r_q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_d;
      r_q_d <= r_q;
    end
  end

  assign o_fall = r_q_d & ~r_q;
endmodule
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_sync_monitor                                                   |
// | Checks VGA line/frame timing, recovers pixel coordinates, sums     |
// | colour per locked frame and counts timing mismatches.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vga_sync_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL        = 1600,
  parameter int V_TOTAL        = 525,
  parameter int CLKS_PER_PIXEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  input  logic        clear,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        pixel_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [7:0]  err_count
);
  localparam int          DIV_W  = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam logic [10:0] c_HLEN = 11'(H_TOTAL);
  localparam logic [9:0]  c_VLEN = 10'(V_TOTAL);

  logic             w_hs_fall, w_vs_fall;
  logic             r_blank, r_blank_d;
  logic [7:0]       r_red, r_grn, r_blu;
  mon_state_t       r_state;
  logic [10:0]      r_hcnt;
  logic [9:0]       r_vcnt;
  logic             r_first, r_bad;
  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_col, r_row;
  logic             r_pend, r_line_act;
  logic [31:0]      r_sum, r_frame_sum;
  logic [7:0]       r_err_count;

  sync_edge_det u_hs_det (.clk(clk), .rst(reset), .i_d(HS), .o_fall(w_hs_fall));
  sync_edge_det u_vs_det (.clk(clk), .rst(reset), .i_d(VS), .o_fall(w_vs_fall));

  logic w_hlen_bad, w_acq_bad, w_err_h, w_err_v, w_any_err, w_pix, w_blank_fall;
  logic [9:0]  w_row;
  logic [31:0] w_rgb;

  assign w_hlen_bad   = w_hs_fall && ((r_hcnt + 11'd1) != c_HLEN);
  // The first HS fall after acquisition started is measured from the VS edge, not a line start.
  assign w_acq_bad    = w_hlen_bad && !r_first;
  assign w_err_h      = (r_state == ST_LOCKED) && w_hlen_bad;
  assign w_err_v      = (r_state == ST_LOCKED) && w_vs_fall && (r_vcnt != c_VLEN);
  assign w_any_err    = w_err_h || w_err_v;
  assign w_pix        = !r_blank && (r_div == '0);
  assign w_blank_fall = r_blank_d && !r_blank;
  assign w_row        = (w_blank_fall && r_pend && (r_row != COORD_MAX)) ? r_row + 10'd1 : r_row;
  assign w_rgb        = 32'(r_red) + 32'(r_grn) + 32'(r_blu);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank     <= 1'b1;
      r_blank_d   <= 1'b1;
      r_red       <= '0;
      r_grn       <= '0;
      r_blu       <= '0;
      r_state     <= ST_SEARCH;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_first     <= 1'b0;
      r_bad       <= 1'b0;
      r_div       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_pend      <= 1'b0;
      r_line_act  <= 1'b0;
      r_sum       <= '0;
      r_frame_sum <= '0;
      r_err_count <= '0;
    end else begin
      r_blank   <= blank;
      r_blank_d <= r_blank;
      r_red     <= R;
      r_grn     <= G;
      r_blu     <= B;

      if (w_hs_fall || ((r_state == ST_SEARCH) && w_vs_fall)) r_hcnt <= '0;
      else if (r_hcnt != '1)                                  r_hcnt <= r_hcnt + 11'd1;

      if (w_vs_fall)                         r_vcnt <= '0;
      else if (w_hs_fall && (r_vcnt != '1)) r_vcnt <= r_vcnt + 10'd1;

      case (r_state)
        ST_SEARCH: begin
          if (w_vs_fall) begin
            r_state <= ST_ACQUIRE;
            r_first <= 1'b1;
            r_bad   <= 1'b0;
          end
        end
        ST_ACQUIRE: begin
          if (w_hs_fall) r_first <= 1'b0;
          if (w_acq_bad) r_bad   <= 1'b1;
          if (w_vs_fall) begin
            r_bad <= 1'b0;
            if ((r_vcnt == c_VLEN) && !r_bad && !w_acq_bad) r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_any_err) r_state <= ST_SEARCH;
        end
        default: r_state <= ST_SEARCH;
      endcase

      if (r_blank)                                     r_div <= '0;
      else if (r_div == DIV_W'(CLKS_PER_PIXEL - 1))    r_div <= '0;
      else                                             r_div <= r_div + DIV_W'(1);

      if (w_hs_fall)                          r_col <= '0;
      else if (w_pix && (r_col != COORD_MAX)) r_col <= r_col + 10'd1;

      // A row advances on the first active span following a line that carried pixels.
      if (w_vs_fall) begin
        r_row      <= '0;
        r_pend     <= 1'b0;
        r_line_act <= 1'b0;
      end else begin
        r_row <= w_row;
        if (w_blank_fall) r_pend <= 1'b0;
        if (w_hs_fall) begin
          if (r_line_act) r_pend <= 1'b1;
          r_line_act <= 1'b0;
        end else if (w_pix) begin
          r_line_act <= 1'b1;
        end
      end

      if (r_state != ST_LOCKED) begin
        r_sum <= '0;
      end else if (w_vs_fall) begin
        r_frame_sum <= r_sum;
        r_sum       <= '0;
      end else if (w_pix) begin
        r_sum <= r_sum + w_rgb;
      end

      if (clear)                              r_err_count <= {7'd0, w_any_err};
      else if (w_any_err && (r_err_count != '1)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign row         = w_row;
  assign col         = r_col;
  assign pixel_valid = w_pix;
  assign locked      = (r_state == ST_LOCKED);
  assign frame_done  = (r_state == ST_LOCKED) && w_vs_fall;
  assign frame_sum   = r_frame_sum;
  assign err_hlen    = w_err_h;
  assign err_vlen    = w_err_v;
  assign err_count   = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_sync_monitor                                                |
// | Directed frame-level bench for vga_sync_monitor on a small raster. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_vga_sync_monitor;
  localparam int H   = 20;
  localparam int V   = 6;
  localparam int CPP = 2;
  localparam int NV  = 13;

  logic        clk = 1'b0;
  logic        reset, HS, VS, blank, clear;
  logic [7:0]  R, G, B;
  logic [9:0]  row, col;
  logic        pixel_valid, locked, frame_done, err_hlen, err_vlen;
  logic [31:0] frame_sum;
  logic [7:0]  err_count;

  vga_sync_monitor #(.H_TOTAL(H), .V_TOTAL(V), .CLKS_PER_PIXEL(CPP)) dut (
    .clk(clk), .reset(reset), .HS(HS), .VS(VS), .blank(blank),
    .R(R), .G(G), .B(B), .clear(clear),
    .row(row), .col(col), .pixel_valid(pixel_valid), .locked(locked),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .err_hlen(err_hlen), .err_vlen(err_vlen), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raster: HS low x<2, VS falls at line 0 x=3, active pixels lines 2..4, x 6..13.
  logic [7:0] cr, cg, cb;
  int g_clr_y = -1;
  int g_clr_x = -1;

  task automatic do_cycle(input int x, input int y);
    HS    = (x < 2) ? 1'b0 : 1'b1;
    VS    = ((y == 0 && x >= 3) || (y == 1 && x < 3)) ? 1'b0 : 1'b1;
    blank = (y >= 2 && y < 5 && x >= 6 && x < 14) ? 1'b0 : 1'b1;
    R = cr; G = cg; B = cb;
    clear = (y == g_clr_y && x == g_clr_x);
    @(posedge clk); #1;
  endtask

  task automatic gen_line(input int len, input int y);
    for (int x = 0; x < len; x++) do_cycle(x, y);
  endtask

  task automatic gen_frame(input int nl, input int sy, input int slen);
    for (int y = 0; y < nl; y++) gen_line((y == sy) ? slen : H, y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      HS = 1'b1; VS = 1'b1; blank = 1'b1; clear = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  int m_pix, m_fd, m_eh, m_ev;
  logic [9:0] m_fr, m_fc, m_lr, m_lc;

  task automatic clr_mon();
    m_pix = 0; m_fd = 0; m_eh = 0; m_ev = 0;
    m_fr = '1; m_fc = '1; m_lr = '1; m_lc = '1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid) begin
        if (m_pix == 0) begin m_fr = row; m_fc = col; end
        m_lr = row; m_lc = col;
        m_pix++;
      end
      if (frame_done) m_fd++;
      if (err_hlen)   m_eh++;
      if (err_vlen)   m_ev++;
    end
  end

  typedef struct {
    logic [7:0]  r, g, b;
    int          nl, sy;
    logic        lock;
    int          fd, eh, ev;
    logic [7:0]  errc;
    logic [31:0] fsum;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk_all_zero(input string tag);
    chk({tag, "_row"},   32'(row), 0);
    chk({tag, "_col"},   32'(col), 0);
    chk({tag, "_pv"},    32'(pixel_valid), 0);
    chk({tag, "_lock"},  32'(locked), 0);
    chk({tag, "_fd"},    32'(frame_done), 0);
    chk({tag, "_fsum"},  frame_sum, 0);
    chk({tag, "_eh"},    32'(err_hlen), 0);
    chk({tag, "_ev"},    32'(err_vlen), 0);
    chk({tag, "_errc"},  32'(err_count), 0);
  endtask

  initial begin
    //              r    g    b   nl sy lock fd eh ev errc  fsum
    tbl[0]  = '{8'd32, 8'd32, 8'd32, 6, -1, 1'b0, 0, 0, 0, 8'd0, 32'd0};
    tbl[1]  = '{8'd32, 8'd32, 8'd32, 6, -1, 1'b1, 0, 0, 0, 8'd0, 32'd0};
    tbl[2]  = '{8'd1,  8'd2,  8'd3,  6, -1, 1'b1, 1, 0, 0, 8'd0, 32'd1152};
    tbl[3]  = '{8'd5,  8'd5,  8'd5,  6,  3, 1'b0, 1, 1, 0, 8'd1, 32'd72};
    tbl[4]  = '{8'd7,  8'd7,  8'd7,  6, -1, 1'b0, 0, 0, 0, 8'd1, 32'd72};
    tbl[5]  = '{8'd10, 8'd20, 8'd30, 6, -1, 1'b1, 0, 0, 0, 8'd1, 32'd72};
    tbl[6]  = '{8'd255,8'd255,8'd255,6, -1, 1'b1, 1, 0, 0, 8'd1, 32'd720};
    tbl[7]  = '{8'd0,  8'd0,  8'd1,  5, -1, 1'b1, 1, 0, 0, 8'd1, 32'd9180};
    tbl[8]  = '{8'd2,  8'd2,  8'd2,  6, -1, 1'b0, 1, 0, 1, 8'd2, 32'd12};
    tbl[9]  = '{8'd3,  8'd3,  8'd3,  6,  3, 1'b0, 0, 0, 0, 8'd2, 32'd12};
    tbl[10] = '{8'd4,  8'd4,  8'd4,  6, -1, 1'b0, 0, 0, 0, 8'd2, 32'd12};
    tbl[11] = '{8'd32, 8'd32, 8'd32, 6, -1, 1'b1, 0, 0, 0, 8'd2, 32'd12};
    tbl[12] = '{8'd9,  8'd9,  8'd9,  6, -1, 1'b1, 1, 0, 0, 8'd2, 32'd1152};

    cr = 8'd0; cg = 8'd0; cb = 8'd0;
    clr_mon();
    reset = 1'b1;
    idle(3);
    chk_all_zero("rst");
    reset = 1'b0;
    idle(4);

    for (int i = 0; i < NV; i++) begin
      cr = tbl[i].r; cg = tbl[i].g; cb = tbl[i].b;
      clr_mon();
      gen_frame(tbl[i].nl, tbl[i].sy, H - 1);
      chk($sformatf("f%0d_lock", i), 32'(locked), 32'(tbl[i].lock));
      chk($sformatf("f%0d_fd", i),   m_fd, tbl[i].fd);
      chk($sformatf("f%0d_eh", i),   m_eh, tbl[i].eh);
      chk($sformatf("f%0d_ev", i),   m_ev, tbl[i].ev);
      chk($sformatf("f%0d_errc", i), 32'(err_count), 32'(tbl[i].errc));
      chk($sformatf("f%0d_fsum", i), frame_sum, tbl[i].fsum);
      chk($sformatf("f%0d_npix", i), m_pix, 12);
      chk($sformatf("f%0d_first", i), {12'd0, m_fr, m_fc}, {12'd0, 10'd0, 10'd0});
      chk($sformatf("f%0d_last", i),  {12'd0, m_lr, m_lc}, {12'd0, 10'd2, 10'd3});
    end

    // Reset in the middle of an active line of a locked frame.
    cr = 8'd32; cg = 8'd32; cb = 8'd32;
    for (int y = 0; y < 3; y++) gen_line(H, y);
    for (int x = 0; x < 8; x++) do_cycle(x, 3);
    reset = 1'b1;
    do_cycle(8, 3);
    do_cycle(9, 3);
    reset = 1'b0;
    chk_all_zero("midrst");
    for (int x = 10; x < H; x++) do_cycle(x, 3);
    gen_line(H, 4);
    gen_line(H, 5);
    chk("midrst_partial_lock", 32'(locked), 0);
    gen_frame(V, -1, H - 1);
    chk("midrst_acq_lock", 32'(locked), 0);
    gen_frame(V, -1, H - 1);
    chk("midrst_relock", 32'(locked), 1);
    chk("midrst_errc", 32'(err_count), 0);

    // Repeated lock/short-line cycles to drive err_count into saturation.
    clr_mon();
    for (int k = 0; k < 258; k++) begin
      gen_frame(3, 1, 3);
      gen_frame(V, -1, H - 1);
    end
    chk("sat_eh_pulses", m_eh, 258);
    chk("sat_errc", 32'(err_count), 255);

    g_clr_y = 2; g_clr_x = 1;
    clr_mon();
    gen_frame(3, 1, 3);
    chk("clr_err_eh", m_eh, 1);
    chk("clr_err_errc", 32'(err_count), 1);

    g_clr_y = 3; g_clr_x = 5;
    gen_frame(V, -1, H - 1);
    g_clr_y = -1; g_clr_x = -1;
    chk("clr_only_errc", 32'(err_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
